// File: rtl/mult_sweep_pkg.sv
// Shared types and helpers for the multiplier operand sweep checker.
package mult_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Legal range of register stages between the operand outputs and result_i.
  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 4;

  function automatic bit latency_legal(input int unsigned lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

  // Number of operand pairs in a full sweep of two n_in-bit operands.
  function automatic int unsigned nv(input int unsigned n_in);
    return 32'd1 << (2 * n_in);
  endfunction

  // Full-width product truncated to n_out bits; only the golden value is truncated.
  function automatic longint unsigned golden_product(input longint unsigned a,
                                                     input longint unsigned b,
                                                     input int unsigned     n_out);
    longint unsigned p;
    p = a * b;
    if (n_out < 64) p = p & ((64'd1 << n_out) - 64'd1);
    return p;
  endfunction

endpackage

// File: rtl/operand_sweep_checker_tag_pipe.sv
// sweep_tag_pipe: shift register carrying {valid, data} alongside the
// multiplier pipeline so each returning result meets its own operands.
module sweep_tag_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_ci,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Valid bits shift every cycle and are cleared by reset.
  always_ff @(posedge clk_ci or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // Payload shifts alongside the valids.
  always_ff @(posedge clk_ci) begin
    // NOTE: payload storage has no reset; it is only consumed when its valid bit is set.
    data_q[0] <= data_i;
    for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/operand_sweep_checker.sv
// operand_sweep_checker: drives every (a, b) pair into a registered multiplier,
// aligns the returning results with a tag pipeline and counts mismatches
// against the golden product, remembering the first failing vector.
module operand_sweep_checker
  import mult_sweep_pkg::*;
#(
  parameter int unsigned N_IN    = 2,
  parameter int unsigned N_OUT   = 4,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk_ci,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic [N_IN-1:0]   operand_a_o,
  output logic [N_IN-1:0]   operand_b_o,
  input  logic [N_OUT-1:0]  result_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [2*N_IN:0]   err_count_o,
  output logic [N_IN-1:0]   fail_a_o,
  output logic [N_IN-1:0]   fail_b_o,
  output logic [N_OUT-1:0]  fail_result_o
);

  localparam int unsigned IW = 2 * N_IN;
  localparam int unsigned EW = 2 * N_IN + 1;
  localparam int unsigned NV = nv(N_IN);
  localparam int unsigned CW = 3;

  if (!latency_legal(LATENCY)) begin : g_bad_latency
    $error("operand_sweep_checker: LATENCY must be in 1..4");
  end

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q;
  logic [CW-1:0]     drain_q;
  logic [EW-1:0]     err_q;
  logic [N_IN-1:0]   fail_a_q, fail_b_q;
  logic [N_OUT-1:0]  fail_res_q;
  logic              start_sweep, last_vec;

  logic              tag_valid;
  logic [IW-1:0]     tag_data;
  logic [N_IN-1:0]   tag_a, tag_b;
  logic [N_OUT-1:0]  expected;
  logic              mismatch;

  // Next-state logic: start is honoured only outside DRIVE/DRAIN.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    start_sweep = 1'b0;
    last_vec    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = DRIVE;
          start_sweep = 1'b1;
        end
      end
      DRIVE: begin
        if (idx_q == IW'(NV - 1)) begin
          state_d  = DRAIN;
          last_vec = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_ci or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Vector index: steps through all pairs in DRIVE and wraps to 0 on the last one.
  always_ff @(posedge clk_ci or negedge rst_ni) begin
    if (!rst_ni)               idx_q <= '0;
    else if (start_sweep)      idx_q <= '0;
    else if (state_q == DRIVE) idx_q <= idx_q + IW'(1);
  end

  // Drain counter: waits for the last in-flight result to come back.
  always_ff @(posedge clk_ci or negedge rst_ni) begin
    if (!rst_ni)                                 drain_q <= '0;
    else if (last_vec)                           drain_q <= CW'(LATENCY - 1);
    else if (state_q == DRAIN && drain_q != '0)  drain_q <= drain_q - CW'(1);
  end

  sweep_tag_pipe #(
    .DEPTH (LATENCY),
    .WIDTH (IW)
  ) u_tag_pipe (
    .clk_ci  (clk_ci),
    .rst_ni  (rst_ni),
    .valid_i (state_q == DRIVE),
    .data_i  (idx_q),
    .valid_o (tag_valid),
    .data_o  (tag_data)
  );

  assign tag_a    = tag_data[N_IN-1:0];
  assign tag_b    = tag_data[IW-1:N_IN];
  assign expected = N_OUT'(golden_product(64'(tag_a), 64'(tag_b), N_OUT));
  assign mismatch = tag_valid && (result_i != expected);

  // Error bookkeeping: saturating count, first failing vector captured once.
  always_ff @(posedge clk_ci or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q      <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_res_q <= '0;
    end else if (start_sweep) begin
      err_q      <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_res_q <= '0;
    end else if (mismatch) begin
      if (err_q != '1) err_q <= err_q + EW'(1);
      if (err_q == '0) begin
        fail_a_q   <= tag_a;
        fail_b_q   <= tag_b;
        fail_res_q <= result_i;
      end
    end
  end

  assign operand_a_o   = idx_q[N_IN-1:0];
  assign operand_b_o   = idx_q[IW-1:N_IN];
  assign busy_o        = (state_q == DRIVE) || (state_q == DRAIN);
  assign done_o        = (state_q == DONE);
  assign pass_o        = (state_q == DONE) && (err_q == '0);
  assign err_count_o   = err_q;
  assign fail_a_o      = fail_a_q;
  assign fail_b_o      = fail_b_q;
  assign fail_result_o = fail_res_q;

endmodule

// File: tb/tb_operand_sweep_checker.sv
// Bench: two checkers (LATENCY 1 and 2) each fed by a behavioural multiplier
// with configurable stuck-bit masks and pipeline depth.
module tb_operand_sweep_checker;

  localparam int NV = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] a1, b1, fa1, fb1, a2, b2, fa2, fb2;
  logic [3:0] res1, fr1, res2, fr2;
  logic       busy1, done1, pass1, busy2, done2, pass2;
  logic [4:0] err1, err2;

  logic [3:0] and_m = 4'hF;
  logic [3:0] or_m  = 4'h0;
  int         stages1 = 1;

  int n_checks = 0;
  int n_fail   = 0;

  operand_sweep_checker #(.N_IN(2), .N_OUT(4), .LATENCY(1)) dut1 (
    .clk_ci(clk), .rst_ni(rst_n), .start_i(start),
    .operand_a_o(a1), .operand_b_o(b1), .result_i(res1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1),
    .fail_a_o(fa1), .fail_b_o(fb1), .fail_result_o(fr1));

  operand_sweep_checker #(.N_IN(2), .N_OUT(4), .LATENCY(2)) dut2 (
    .clk_ci(clk), .rst_ni(rst_n), .start_i(start),
    .operand_a_o(a2), .operand_b_o(b2), .result_i(res2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(err2),
    .fail_a_o(fa2), .fail_b_o(fb2), .fail_result_o(fr2));

  // Multiplier under test, with stuck-at masks applied to its output.
  function automatic logic [3:0] faulty(input int a, input int b, input logic [3:0] am,
                                        input logic [3:0] om);
    int p;
    p = (a * b) % 16;
    return (4'(p) & am) | om;
  endfunction

  logic [3:0] m1_r1, m1_r2, m2_r1, m2_r2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_r1 <= '0; m1_r2 <= '0; m2_r1 <= '0; m2_r2 <= '0;
    end else begin
      m1_r1 <= faulty(int'(a1), int'(b1), and_m, or_m);
      m1_r2 <= m1_r1;
      m2_r1 <= faulty(int'(a2), int'(b2), and_m, or_m);
      m2_r2 <= m2_r1;
    end
  end
  assign res1 = (stages1 == 1) ? m1_r1 : m1_r2;
  assign res2 = m2_r2;

  typedef struct {int err; int fa; int fb; int fr; int pass;} exp_t;

  // Reference: vector k is compared with the faulty product of the operands
  // presented 'shift' cycles earlier; outside the sweep the operands are (0,0).
  function automatic exp_t model(input logic [3:0] am, input logic [3:0] om, input int shift);
    exp_t e;
    int j, aj, bj, obs, gold;
    e = '{err: 0, fa: 0, fb: 0, fr: 0, pass: 0};
    for (int k = 0; k < NV; k++) begin
      gold = ((k % 4) * (k / 4)) % 16;
      j = k - shift;
      aj = (j >= 0 && j < NV) ? j % 4 : 0;
      bj = (j >= 0 && j < NV) ? j / 4 : 0;
      obs = int'(faulty(aj, bj, am, om));
      if (obs != gold) begin
        if (e.err == 0) begin e.fa = k % 4; e.fb = k / 4; e.fr = obs; end
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic setup(input logic [3:0] am, input logic [3:0] om, input int st);
    @(negedge clk);
    and_m = am; or_m = om; stages1 = st;
    repeat (4) @(negedge clk);
  endtask

  // One sweep; returns the cycle (after the start edge) at which each done rises.
  task automatic run_sweep(input int pulse_at, output int d1, output int d2,
                           output int op_errs, output int both_high);
    d1 = -1; d2 = -1; op_errs = 0; both_high = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (a1 !== 2'd0 || b1 !== 2'd0) op_errs++;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = (c == pulse_at) ? 1'b1 : 1'b0;
      if (c < NV && (a1 !== 2'(c) || b1 !== 2'(c / 4))) op_errs++;
      if (c == NV && (a1 !== 2'd0 || b1 !== 2'd0)) op_errs++;
      if ((busy1 && done1) || (busy2 && done2)) both_high++;
      if (done1 && d1 < 0) d1 = c;
      if (done2 && d2 < 0) d2 = c;
      if (d1 >= 0 && d2 >= 0) break;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [3:0] am; logic [3:0] om; int st; int pulse;
    int err; int fa; int fb; int fr; int pass;
  } vec_t;

  task automatic sweep_and_check(input string tag, input logic [3:0] am, input logic [3:0] om,
                                 input int st, input int pulse, input exp_t e1);
    int d1, d2, oe, bh;
    exp_t e2;
    e2 = model(am, om, 0);
    setup(am, om, st);
    run_sweep(pulse, d1, d2, oe, bh);
    check({tag, "_done1_cyc"}, d1, NV + 1);
    check({tag, "_done2_cyc"}, d2, NV + 2);
    check({tag, "_operands"}, oe, 0);
    check({tag, "_busy_and_done"}, bh, 0);
    check({tag, "_err1"}, err1, e1.err);
    check({tag, "_pass1"}, pass1, e1.pass);
    check({tag, "_fail_a1"}, fa1, e1.fa);
    check({tag, "_fail_b1"}, fb1, e1.fb);
    check({tag, "_fail_res1"}, fr1, e1.fr);
    check({tag, "_err2"}, err2, e2.err);
    check({tag, "_pass2"}, pass2, e2.pass);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_err1_hold"}, err1, e1.err);
    check({tag, "_done1_hold"}, done1, 1);
  endtask

  initial begin
    vec_t tbl[6];
    exp_t e;
    logic [3:0] am, om;
    int st;

    tbl[0] = '{am: 4'hF, om: 4'h0, st: 1, pulse: -1, err: 0,  fa: 0, fb: 0, fr: 0, pass: 1};
    tbl[1] = '{am: 4'h7, om: 4'h0, st: 1, pulse: -1, err: 1,  fa: 3, fb: 3, fr: 1, pass: 0};
    tbl[2] = '{am: 4'hF, om: 4'h1, st: 1, pulse: -1, err: 12, fa: 0, fb: 0, fr: 1, pass: 0};
    tbl[3] = '{am: 4'hF, om: 4'h0, st: 1, pulse: 5,  err: 0,  fa: 0, fb: 0, fr: 0, pass: 1};
    tbl[4] = '{am: 4'hF, om: 4'h0, st: 2, pulse: -1, err: 11, fa: 1, fb: 1, fr: 0, pass: 0};
    tbl[5] = '{am: 4'hF, om: 4'h0, st: 1, pulse: -1, err: 0,  fa: 0, fb: 0, fr: 0, pass: 1};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_err", err1, 0);
    check("rst_ops", {a1, b1}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_pass", pass1, 0);

    // Directed vectors; each sweep after the first restarts from DONE.
    for (int i = 0; i < 6; i++) begin
      e = '{err: tbl[i].err, fa: tbl[i].fa, fb: tbl[i].fb, fr: tbl[i].fr, pass: tbl[i].pass};
      sweep_and_check($sformatf("v%0d", i), tbl[i].am, tbl[i].om, tbl[i].st, tbl[i].pulse, e);
    end

    // Asynchronous reset in cycle 8 of DRIVE with bit 0 stuck at 1.
    setup(4'hF, 4'h1, 1);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_err_before_rst", err1, 6);
    check("mid_busy_before_rst", busy1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_busy", busy1, 0);
    check("rst_async_ops", {a1, b1}, 0);
    check("rst_async_err", err1, 0);
    check("rst_async_fail", {fa1, fb1, fr1}, 0);
    check("rst_async_done_pass", {done1, pass1, done2, pass2}, 0);
    @(negedge clk) rst_n = 1'b1;
    e = '{err: 0, fa: 0, fb: 0, fr: 0, pass: 1};
    sweep_and_check("post_rst", 4'hF, 4'h0, 1, -1, e);

    // Randomised stuck-bit masks and pipeline depth against the reference model.
    for (int r = 0; r < 6; r++) begin
      am = 4'hF & ~(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      om = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      st = int'($urandom_range(1, 2));
      e = model(am, om, st - 1);
      sweep_and_check($sformatf("rnd%0d", r), am, om, st, -1, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
